// File: rtl/uart_sched_pkg.sv
`default_nettype none
// ============================================================================
//  uart_sched_pkg : shared state encoding and defaults for the UART scheduler
//  Rev 1.0
// ============================================================================
package uart_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SEND  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FLUSH = 3'd4
    } sched_state_e;

    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

    // Index width for an N-entry one-hot vector, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : uart_sched_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  rr_arbiter : combinational round-robin pick, lowest index from the pointer
//  Rev 1.0
// ============================================================================
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    logic          w_found;
    logic [IW:0]   w_cand;

    // Walk the requesters starting at the pointer, wrapping at NREQ.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, ptr_i} + (IW+1)'(k);
            if (w_cand >= (IW+1)'(NREQ)) begin
                w_cand = w_cand - (IW+1)'(NREQ);
            end
            if (!w_found && req_i[w_cand[IW-1:0]]) begin
                w_found                  = 1'b1;
                gnt_o[w_cand[IW-1:0]]    = 1'b1;
                idx_o                    = w_cand[IW-1:0];
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  uart_tx_scheduler : packet-level round-robin sharing of one UART transmitter
//  Rev 1.0
// ============================================================================
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int          NREQ    = 4,
    parameter int          TW      = 16,
    parameter logic [TW-1:0] TIMEOUT = TW'(TIMEOUT_DEFAULT)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [NREQ-1:0]   grant_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_send_o,
    input  logic              tx_busy_i,
    output logic              timeout_o,
    output logic              active_o
);

    localparam int            IW      = idx_w(NREQ);
    localparam logic          WD_EN   = (TIMEOUT != '0);
    // Expiry is taken one count early so FLUSH starts exactly TIMEOUT cycles after entry.
    localparam logic [TW-1:0] WD_LAST = TIMEOUT - TW'(1);

    sched_state_e    state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            last_q, last_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    logic [NREQ-1:0] w_arb_gnt;
    logic [IW-1:0]   w_arb_idx;
    logic [NREQ-1:0] w_ready;
    logic            w_release;
    logic            w_gvalid;
    logic            w_glast;
    logic [7:0]      w_gdata;
    logic [IW-1:0]   w_next_ptr;
    logic            w_wd_expired;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (w_arb_gnt),
        .idx_o (w_arb_idx)
    );

    assign w_gvalid     = req_valid_i[gidx_q];
    assign w_glast      = req_last_i[gidx_q];
    assign w_gdata      = req_data_i[{gidx_q, 3'b000} +: 8];
    assign w_next_ptr   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
    assign w_wd_expired = WD_EN && (cnt_q == WD_LAST);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        w_ready   = '0;
        w_release = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!tx_busy_i && (|req_valid_i)) begin
                    grant_d = w_arb_gnt;
                    gidx_d  = w_arb_idx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_gvalid) begin
                    w_ready[gidx_q] = 1'b1;
                    tx_data_d       = w_gdata;
                    last_d          = w_glast;
                    cnt_d           = '0;
                    state_d         = ST_SEND;
                end
            end
            ST_SEND: begin
                cnt_d = cnt_q + 1'b1;
                if (tx_busy_i) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else if (w_wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (!tx_busy_i) begin
                    if (last_q) begin
                        w_release = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (w_wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // The aborted byte may already have been the packet's last one.
                if (last_q) begin
                    w_release = 1'b1;
                end else if (w_gvalid) begin
                    w_ready[gidx_q] = 1'b1;
                    if (w_glast) begin
                        w_release = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (w_release) begin
            grant_d = '0;
            ptr_d   = w_next_ptr;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            tx_data_q <= 8'h00;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign req_ready_o = w_ready;
    assign grant_o     = grant_q;
    assign tx_data_o   = tx_data_q;
    assign tx_send_o   = (state_q == ST_SEND);
    assign timeout_o   = timeout_q;
    assign active_o    = (state_q != ST_IDLE);

endmodule : uart_tx_scheduler
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  tb_uart_tx_scheduler : randomized + directed bench with a packet-level model
//  Rev 1.0
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int NREQ     = 4;
    localparam int BUSY_CYC = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        tx_data;
    logic              tx_send;
    logic              tx_busy;
    logic              timeout;
    logic              active;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NREQ    (NREQ),
        .TW      (16),
        .TIMEOUT (16'd100)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .grant_o     (grant),
        .tx_data_o   (tx_data),
        .tx_send_o   (tx_send),
        .tx_busy_i   (tx_busy),
        .timeout_o   (timeout),
        .active_o    (active)
    );

    int checks   = 0;
    int failures = 0;

    logic [8:0]      rq [NREQ][$];      // bit 8 marks the last byte of a packet
    logic [8:0]      cp [NREQ][$];
    logic            mid [NREQ];
    int              ready_cnt [NREQ];
    logic [NREQ-1:0] gap_force;
    logic [NREQ-1:0] acc;
    int              gap_rate;
    logic            uart_dead;
    int              busy_cnt;
    logic            prev_send;
    int              cyc;
    int              send_cyc, timeout_cyc, timeout_cnt, send_cnt;
    logic            tmo_send;
    int              model_ptr;
    logic [7:0]      exp_byte [$];
    int              exp_src  [$];
    logic [7:0]      sent_log [$];
    int              sent_src [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: retire accepted bytes, run the UART model, log, drive, sample ready.
    task automatic step();
        int src;
        logic [8:0] b;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && rq[i].size() != 0) begin
                b = rq[i].pop_front();
                mid[i] = !b[8];
                ready_cnt[i]++;
            end
        end
        if (tx_send && !prev_send) begin
            src = -1;
            for (int i = 0; i < NREQ; i++) if (grant[i]) src = i;
            sent_log.push_back(tx_data);
            sent_src.push_back(src);
            send_cyc = cyc;
            send_cnt++;
        end
        if (timeout) begin
            timeout_cnt++;
            timeout_cyc = cyc;
            tmo_send    = tx_send;
        end
        prev_send = tx_send;
        if (uart_dead) busy_cnt = 0;
        else if (busy_cnt > 0) busy_cnt--;
        else if (tx_send) busy_cnt = BUSY_CYC;
        tx_busy = (busy_cnt > 0);
        check("grant_onehot", 32'((grant & (grant - 1'b1)) == '0), 1);
        check("active_vs_grant", 32'(active), 32'(grant != '0));
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (rq[i].size() != 0) && !gap_force[i] &&
                           !(mid[i] && gap_rate > 0 && $urandom_range(gap_rate - 1) == 0);
            b = (rq[i].size() != 0) ? rq[i][0] : 9'h000;
            req_data[8*i +: 8] = b[7:0];
            req_last[i]        = b[8];
        end
        #1;
        acc = req_ready & req_valid;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            rq[i].delete();
            mid[i]       = 1'b0;
            ready_cnt[i] = 0;
        end
        acc = '0;
        gap_force = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        step();
        step();
        reset = 1'b0;
        model_ptr = 0;
        sent_log.delete();
        sent_src.delete();
    endtask

    task automatic add_pkt(input int r, input int len, input logic [7:0] base);
        for (int k = 0; k < len; k++) rq[r].push_back({(k == len - 1), base + 8'(k)});
    endtask

    // Packet-granular round robin over everything currently queued.
    task automatic model_predict();
        int sel;
        logic [8:0] b;
        for (int i = 0; i < NREQ; i++) cp[i] = rq[i];
        forever begin
            sel = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (sel < 0 && cp[(model_ptr + k) % NREQ].size() != 0) sel = (model_ptr + k) % NREQ;
            end
            if (sel < 0) break;
            do begin
                b = cp[sel].pop_front();
                exp_byte.push_back(b[7:0]);
                exp_src.push_back(sel);
            end while (!b[8]);
            model_ptr = (sel + 1) % NREQ;
        end
    endtask

    task automatic run_idle(input int budget, input string tag);
        int n = 0;
        step();
        while (!(all_empty() && !active) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done"}, 32'(n < budget), 1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, sent_log.size(), exp_byte.size());
        for (int k = 0; k < exp_byte.size() && k < sent_log.size(); k++) begin
            check({tag, "_byte"}, 32'(sent_log[k]), 32'(exp_byte[k]));
            check({tag, "_src"}, sent_src[k], exp_src[k]);
        end
        sent_log.delete();
        sent_src.delete();
        exp_byte.delete();
        exp_src.delete();
    endtask

    task automatic wait_ready(input int r, input int target, input string tag);
        int n = 0;
        while (ready_cnt[r] < target && n < 500) begin
            step();
            n++;
        end
        check({tag, "_wait"}, 32'(n < 500), 1);
    endtask

    initial begin
        int r0;
        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        uart_dead = 1'b0; busy_cnt = 0; gap_rate = 0; prev_send = 1'b0; cyc = 0;
        send_cyc = 0; timeout_cyc = 0; timeout_cnt = 0; send_cnt = 0; tmo_send = 1'b0;
        clear_reqs();
        step(); step(); step();
        check("rst_grant", grant, 0);
        check("rst_ready", req_ready, 0);
        check("rst_send", tx_send, 0);
        check("rst_data", tx_data, 0);
        check("rst_timeout", timeout, 0);
        check("rst_active", active, 0);
        reset = 1'b0;
        model_ptr = 0;

        // Single requester, two-byte packet.
        add_pkt(0, 2, 8'h41);
        exp_byte.push_back(8'h41); exp_src.push_back(0);
        exp_byte.push_back(8'h42); exp_src.push_back(0);
        run_idle(400, "single");
        compare_log("single");
        check("single_ready", ready_cnt[0], 2);
        check("single_grant", grant, 0);
        model_ptr = 1;
        add_pkt(0, 1, 8'h50);
        add_pkt(1, 1, 8'h60);
        model_predict();
        run_idle(400, "ptr1");
        compare_log("ptr1");

        // Contention from reset.
        do_reset();
        add_pkt(1, 3, 8'hA1);
        add_pkt(2, 3, 8'hB1);
        model_predict();
        run_idle(600, "contend");
        compare_log("contend");

        // Fairness: all continuously valid with one-byte packets.
        do_reset();
        for (int r = 0; r < NREQ; r++) begin
            add_pkt(r, 1, 8'(8'h10 + r));
            add_pkt(r, 1, 8'(8'h20 + r));
        end
        model_predict();
        run_idle(800, "fair");
        compare_log("fair");

        // Valid gap mid-packet on the owner.
        do_reset();
        add_pkt(3, 2, 8'h31);
        wait_ready(3, 1, "gap");
        gap_force[3] = 1'b1;
        add_pkt(0, 1, 8'h05);
        r0 = send_cnt;
        for (int k = 0; k < 20; k++) step();
        check("gap_grant", grant, 4'b1000);
        check("gap_req0", ready_cnt[0], 0);
        check("gap_sends", send_cnt - r0, 0);
        check("gap_send_low", tx_send, 0);
        gap_force[3] = 1'b0;
        exp_byte.push_back(8'h31); exp_src.push_back(3);
        exp_byte.push_back(8'h32); exp_src.push_back(3);
        exp_byte.push_back(8'h05); exp_src.push_back(0);
        run_idle(400, "gap");
        compare_log("gap");
        model_ptr = 1;

        // Watchdog: UART never answers.
        uart_dead = 1'b1;
        timeout_cnt = 0;
        r0 = ready_cnt[0];
        add_pkt(0, 4, 8'hC0);
        exp_byte.push_back(8'hC0); exp_src.push_back(0);
        run_idle(600, "wdog");
        compare_log("wdog");
        check("wdog_pulses", timeout_cnt, 1);
        check("wdog_delay", timeout_cyc - send_cyc, 100);
        check("wdog_send_low", tmo_send, 0);
        check("wdog_ready", ready_cnt[0] - r0, 4);
        check("wdog_grant", grant, 0);
        uart_dead = 1'b0;
        model_ptr = 1;
        add_pkt(0, 1, 8'h70);
        add_pkt(1, 1, 8'h71);
        model_predict();
        run_idle(400, "wdog_ptr");
        compare_log("wdog_ptr");

        // Reset while draining byte 2 of 3.
        r0 = ready_cnt[2];
        add_pkt(2, 3, 8'hD0);
        wait_ready(2, r0 + 2, "rstdrain");
        step(); step(); step();
        reset = 1'b1;
        step();
        check("rstd_send", tx_send, 0);
        check("rstd_grant", grant, 0);
        check("rstd_active", active, 0);
        check("rstd_data", tx_data, 0);
        reset = 1'b0;
        clear_reqs();
        sent_log.delete();
        sent_src.delete();
        model_ptr = 0;
        add_pkt(3, 1, 8'hE3);
        add_pkt(1, 1, 8'hE1);
        model_predict();
        run_idle(400, "after_rst");
        compare_log("after_rst");

        // Randomized packets with random mid-packet valid gaps.
        gap_rate = 3;
        for (int round = 0; round < 6; round++) begin
            for (int r = 0; r < NREQ; r++) begin
                for (int p = $urandom_range(2); p > 0; p--) begin
                    add_pkt(r, $urandom_range(1, 4), 8'($urandom));
                end
            end
            model_predict();
            run_idle(3000, "rand");
            compare_log("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_scheduler
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART transmitter among NREQ byte-stream requesters, with round-robin packet-level arbitration. It sits between client blocks (command responder, debug logger, status reporter) and the Tx_Data/Tx_Send/Tx_Busy side of the UART. Once a requester is granted, it keeps the transmitter until its byte marked Last has been handed over, so packets are never interleaved. A watchdog aborts a packet if the UART stops answering.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 16'd50000, cycles allowed for Tx_Busy to rise after Tx_Send, or to fall after rising; 0 disables the watchdog
TW, 16, watchdog counter width

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
Req_Valid  input  NREQ  per-requester byte valid
Req_Data  input  8*NREQ  byte of requester i at [8i+7:8i]
Req_Last  input  NREQ  byte is the final byte of its packet
Req_Ready  output  NREQ  one-cycle pulse: byte of requester i accepted
Grant  output  NREQ  one-hot owner of the transmitter, 0 when idle
Tx_Data  output  8  byte to the UART transmitter
Tx_Send  output  1  send request to the UART transmitter
Tx_Busy  input  1  UART transmitter busy
Timeout  output  1  one-cycle pulse when the watchdog aborts a packet
Active  output  1  high while a packet is owned

Behaviour:
- Reset values: Grant=0, Req_Ready=0, Tx_Send=0, Tx_Data=8'h00, Timeout=0, Active=0, priority pointer=0, state=IDLE. Reset mid-packet aborts at once. Tx_Send drops on the cycle after Reset is sampled.
- States: IDLE, LOAD, SEND, DRAIN, FLUSH.
- IDLE: wait for Tx_Busy=0 and any Req_Valid. Round-robin pick starts at the pointer, lowest index first from there. Set Grant and Active, go to LOAD. Arbitration takes 1 cycle.
- LOAD, with the granted requester valid:
  - Latch its byte into Tx_Data and its Last bit internally.
  - Pulse Req_Ready[g] for exactly 1 cycle.
  - Go to SEND with Tx_Send=1.
  - If the granted Req_Valid is low, stay in LOAD. The grant is held and other requesters are not served.
- SEND: Tx_Send=1, Tx_Data stable. On Tx_Busy=1, drop Tx_Send and go to DRAIN.
- DRAIN: wait for Tx_Busy=0.
  - If the latched Last=1: clear Grant and Active, set the pointer to (g+1) mod NREQ, go to IDLE.
  - Otherwise go back to LOAD.
- Per-byte overhead: LOAD takes 1 cycle; each byte costs UART frame time plus 1 cycle.
- Watchdog (when TIMEOUT≠0):
  - The counter resets on entry to SEND and on entry to DRAIN.
  - When it reaches TIMEOUT in SEND or DRAIN: drop Tx_Send, pulse Timeout, go to FLUSH.
- FLUSH: discard the rest of the stalled packet.
  - Pulse Req_Ready[g] for each valid byte of the granted requester until a byte with Last is consumed.
  - Then release the grant and advance the pointer as a normal packet end, and go to IDLE.
  - If the Last byte had already been accepted, go straight to IDLE.
- Simultaneous requests: exactly one grant. With all requesters continuously valid, ownership rotates 0,1,2,3,0…
- Single-byte packet (Valid and Last together): IDLE→LOAD→SEND→DRAIN→IDLE.
- Req_Valid dropping on a non-granted port has no effect. Data is sampled only in LOAD.
- Requester contract: hold Req_Data/Req_Last stable while Req_Valid=1 and Req_Ready=0.
- Grant is never 0 while Active=1, and never has more than one bit set.

Decomposition:
- Package uart_sched_pkg: state encoding constants (IDLE, LOAD, SEND, DRAIN, FLUSH) and the default TIMEOUT.
- Sub-module rr_arbiter:
  - Inputs: request vector and pointer, NREQ wide.
  - Outputs: one-hot grant and encoded index.
  - Combinational; reused by other shared-resource schedulers.

Test Plan:
- Single requester: req0 sends 8'h41, 8'h42(Last) against a UART model with Busy high for 10 cycles → Tx sees 41 then 42; Req_Ready[0] pulses twice; Grant returns to 0; pointer=1.
- Contention: req1 and req2 both valid at the same cycle from reset, with 3-byte packets → full req1 packet (A1..A3), then full req2 packet; no interleaving.
- Round-robin fairness: all 4 continuously valid with 1-byte packets → grant order 0,1,2,3,0,1 over six packets.
- Valid gap mid-packet: req3 drops Valid for 20 cycles between bytes → grant is held, req0 is not served in the gap, Tx_Send stays low in the gap.
- Watchdog: TIMEOUT=100, UART model never raises Busy, req0 sends a 4-byte packet → Timeout pulses 100 cycles after Tx_Send rises; the remaining 3 bytes are flushed with Ready pulses; Grant=0; pointer=1.
- Reset in DRAIN during byte 2 of 3 → next cycle: Tx_Send=0, Grant=0, Active=0, pointer=0; the next request is served normally.
